led_blink_ctrl: RTL and testbench

Multi-channel blink scheduler for the blinking-LED core. It shares one external millisecond strobe `tic` among `NCH` LED channels. Each channel has a software-programmed on-time and off-time in milliseconds plus an enable bit, and runs its own ON/OFF state machine. It sits between the ms tick generator and the LED pins, and is configured through a simple single-cycle write port.

---
 rtl/led_blink_ctrl.sv | 142 ++++++++++++++
 tb/tb_led_blink_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_blink_ctrl.sv
// led_blink_ctrl: NCH independent ON/OFF blink channels sharing one ms strobe.
// Each channel has a CTRL (enable), ON_MS and OFF_MS register reached through
// a single-cycle write port, plus a latched phase length and a tic counter.
module led_blink_ctrl #(
  parameter int NCH = 4,
  parameter int CNT_W = 16,
  localparam int CH_W = $clog2(NCH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tic,
  input  logic                wr_en,
  input  logic [CH_W+1:0]     wr_addr,
  input  logic [CNT_W-1:0]    wr_data,
  output logic [NCH-1:0]      led,
  output logic [NCH-1:0]      cycle_done
);

  typedef enum logic [1:0] {IDLE = 2'd0, ON = 2'd1, OFF = 2'd2} state_t;

  localparam logic [1:0] SEL_CTRL = 2'd0;
  localparam logic [1:0] SEL_ON   = 2'd1;
  localparam logic [1:0] SEL_OFF  = 2'd2;

  state_t             state_q  [NCH];
  state_t             state_d  [NCH];
  logic [CNT_W-1:0]   on_ms_q  [NCH];
  logic [CNT_W-1:0]   on_ms_d  [NCH];
  logic [CNT_W-1:0]   off_ms_q [NCH];
  logic [CNT_W-1:0]   off_ms_d [NCH];
  logic [CNT_W-1:0]   len_q    [NCH];
  logic [CNT_W-1:0]   len_d    [NCH];
  logic [CNT_W-1:0]   cnt_q    [NCH];
  logic [CNT_W-1:0]   cnt_d    [NCH];
  logic [NCH-1:0]     en_q;
  logic [NCH-1:0]     en_d;
  logic [NCH-1:0]     led_d;
  logic [NCH-1:0]     done_d;

  logic [CH_W-1:0]    wr_ch;
  logic [1:0]         wr_sel;

  assign wr_ch  = wr_addr[CH_W+1:2];
  assign wr_sel = wr_addr[1:0];

  // True when the tic being sampled completes the phase. Done one bit wider so
  // a maximal length cannot wrap; a zero length ends on its first tic.
  function automatic logic phase_done(input logic [CNT_W-1:0] cnt,
                                      input logic [CNT_W-1:0] len);
    logic [CNT_W:0] nxt;
    nxt = {1'b0, cnt} + (CNT_W+1)'(1);
    return nxt >= {1'b0, len};
  endfunction

  // Per-channel next state: an enable change wins over a tic; period writes
  // land after the length decision so they only affect the next phase.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      state_d[i]  = state_q[i];
      on_ms_d[i]  = on_ms_q[i];
      off_ms_d[i] = off_ms_q[i];
      len_d[i]    = len_q[i];
      cnt_d[i]    = cnt_q[i];
      en_d[i]     = en_q[i];
      done_d[i]   = 1'b0;

      if (wr_en && (wr_ch == CH_W'(i)) && (wr_sel == SEL_CTRL) &&
          (wr_data[0] != en_q[i])) begin
        en_d[i]  = wr_data[0];
        cnt_d[i] = '0;
        if (!wr_data[0]) begin
          state_d[i] = IDLE;
        end else if (on_ms_q[i] != '0) begin
          state_d[i] = ON;
          len_d[i]   = on_ms_q[i];
        end else begin
          state_d[i] = OFF;
          len_d[i]   = off_ms_q[i];
        end
      end else if (tic && (state_q[i] != IDLE)) begin
        if (phase_done(cnt_q[i], len_q[i])) begin
          cnt_d[i] = '0;
          if (state_q[i] == ON) begin
            if (off_ms_q[i] != '0) begin
              state_d[i] = OFF;
              len_d[i]   = off_ms_q[i];
            end else begin
              len_d[i]   = on_ms_q[i];
            end
          end else begin
            if (on_ms_q[i] != '0) begin
              state_d[i] = ON;
              len_d[i]   = on_ms_q[i];
              done_d[i]  = 1'b1;
            end else begin
              len_d[i]   = off_ms_q[i];
            end
          end
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end

      if (wr_en && (wr_ch == CH_W'(i)) && (wr_sel == SEL_ON)) begin
        on_ms_d[i] = wr_data;
      end
      if (wr_en && (wr_ch == CH_W'(i)) && (wr_sel == SEL_OFF)) begin
        off_ms_d[i] = wr_data;
      end

      led_d[i] = (state_d[i] == ON);
    end
  end

  // State, configuration and registered outputs; reset returns every channel to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i]  <= IDLE;
        on_ms_q[i]  <= '0;
        off_ms_q[i] <= '0;
        len_q[i]    <= '0;
        cnt_q[i]    <= '0;
      end
      en_q       <= '0;
      led        <= '0;
      cycle_done <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i]  <= state_d[i];
        on_ms_q[i]  <= on_ms_d[i];
        off_ms_q[i] <= off_ms_d[i];
        len_q[i]    <= len_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      en_q       <= en_d;
      led        <= led_d;
      cycle_done <= done_d;
    end
  end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Bench for led_blink_ctrl: a phase/remaining-tics model checked every cycle,
// plus directed scenarios with hand-derived durations and pulse counts.
module tb_led_blink_ctrl;

  localparam int NCH   = 4;
  localparam int CNT_W = 16;
  localparam int CH_W  = 2;
  localparam int AW    = CH_W + 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             tic = 1'b0;
  logic             wr_en = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [CNT_W-1:0] wr_data = '0;
  logic [NCH-1:0]   led;
  logic [NCH-1:0]   cycle_done;

  int checks = 0;
  int errors = 0;
  int div = 0;

  led_blink_ctrl #(.NCH(NCH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .tic(tic), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .led(led), .cycle_done(cycle_done)
  );

  always #5 clk = ~clk;

  // Model: phase 0 = dark/idle, 1 = lit, 2 = dark/counting; rem = tics left.
  int             m_phase [NCH];
  int             m_rem   [NCH];
  int             m_on    [NCH];
  int             m_off   [NCH];
  bit             m_en    [NCH];
  logic [NCH-1:0] mled = '0;
  logic [NCH-1:0] mcd  = '0;
  bit             hit;
  int             sel;

  function automatic int tics_of(input int len);
    return (len == 0) ? 1 : len;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        m_phase[i] = 0; m_rem[i] = 0; m_on[i] = 0; m_off[i] = 0; m_en[i] = 0;
      end
      mled = '0;
      mcd  = '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        hit = wr_en && (int'(wr_addr[AW-1:2]) == i);
        sel = int'(wr_addr[1:0]);
        mcd[i] = 1'b0;
        if (hit && sel == 0 && wr_data[0] != m_en[i]) begin
          m_en[i] = wr_data[0];
          if (!m_en[i]) m_phase[i] = 0;
          else if (m_on[i] != 0) begin m_phase[i] = 1; m_rem[i] = tics_of(m_on[i]); end
          else begin m_phase[i] = 2; m_rem[i] = tics_of(m_off[i]); end
        end else if (tic && m_phase[i] != 0) begin
          m_rem[i] = m_rem[i] - 1;
          if (m_rem[i] == 0) begin
            if (m_phase[i] == 1) begin
              if (m_off[i] != 0) begin m_phase[i] = 2; m_rem[i] = m_off[i]; end
              else m_rem[i] = tics_of(m_on[i]);
            end else begin
              if (m_on[i] != 0) begin m_phase[i] = 1; m_rem[i] = m_on[i]; mcd[i] = 1'b1; end
              else m_rem[i] = tics_of(m_off[i]);
            end
          end
        end
        if (hit && sel == 1) m_on[i] = int'(wr_data);
        if (hit && sel == 2) m_off[i] = int'(wr_data);
        mled[i] = (m_phase[i] == 1);
      end
    end
  end

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    checks++;
    if (led !== mled || cycle_done !== mcd) begin
      errors++;
      $display("FAIL model_cmp t=%0t led=%b cycle_done=%b expected led=%b cycle_done=%b",
               $time, led, cycle_done, mled, mcd);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic cyc(input bit we, input logic [AW-1:0] a, input logic [CNT_W-1:0] d);
    @(negedge clk);
    wr_en = we; wr_addr = a; wr_data = d;
    tic = (div == 9);
    div = (div == 9) ? 0 : div + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, '0, '0);
  endtask

  task automatic wr(input int ch, input int s, input int data);
    cyc(1'b1, AW'((ch << 2) | s), CNT_W'(data));
  endtask

  task automatic align_tic();
    while (div != 9) cyc(1'b0, '0, '0);
  endtask

  task automatic run_len(input int ch, input logic val, output int n);
    n = 0;
    while (led[ch] === val && n < 1000) begin
      n++;
      cyc(1'b0, '0, '0);
    end
  endtask

  int n, cnt_a, cnt_b;

  initial begin
    #1 rst_n = 1'b0;
    idle(3);
    chk("reset_led", int'(led), 0);
    chk("reset_cycle_done", int'(cycle_done), 0);
    rst_n = 1'b1;
    idle(2);

    // Configure all channels while disabled; reserved-address writes must do nothing.
    wr(0, 1, 3); wr(0, 2, 2);
    wr(1, 1, 0); wr(1, 2, 4);
    wr(2, 1, 5); wr(2, 2, 0);
    wr(3, 1, 4); wr(3, 2, 2);
    wr(0, 3, 1); wr(3, 3, 7);
    cnt_a = 0;
    for (int i = 0; i < 30; i++) begin cyc(1'b0, '0, '0); cnt_a += int'(led[0]); end
    chk("sel3_no_enable", cnt_a, 0);

    // Ch0 enabled on a tic cycle: that tic is ignored, ON lasts 3 later tics.
    align_tic();
    wr(0, 0, 1);
    idle(1);
    run_len(0, 1'b1, n); chk("ch0_first_on_len", n, 30);
    run_len(0, 1'b0, n); chk("ch0_off_len", n, 20);
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 200; i++) begin
      cyc(1'b0, '0, '0);
      cnt_a += int'(cycle_done[0]);
      cnt_b += int'(led[0]);
    end
    chk("ch0_done_pulses", cnt_a, 4);
    chk("ch0_lit_cycles", cnt_b, 120);
    wr(0, 0, 1);
    idle(7);

    // Ch3: shortening ON during ON keeps the current phase, next ON is 1 tic.
    align_tic();
    wr(3, 0, 1);
    wr(3, 1, 1);
    run_len(3, 1'b1, n); chk("ch3_cur_on_len", n, 40);
    run_len(3, 1'b0, n); chk("ch3_off_len", n, 20);
    run_len(3, 1'b1, n); chk("ch3_next_on_len", n, 10);
    run_len(3, 1'b0, n); chk("ch3_off_len2", n, 20);
    run_len(3, 1'b1, n); chk("ch3_on_len2", n, 10);

    // Ch1: on_ms = 0 keeps it dark; a later on_ms write lands at the OFF end.
    align_tic();
    wr(1, 0, 1);
    cnt_a = 0;
    for (int i = 0; i < 45; i++) begin cyc(1'b0, '0, '0); cnt_a += int'(led[1]); end
    chk("ch1_dark_on0", cnt_a, 0);
    wr(1, 1, 2);
    run_len(1, 1'b0, n); chk("ch1_wait_to_rise", n, 35);
    run_len(1, 1'b1, n); chk("ch1_on_len", n, 20);

    // Ch2: off_ms = 0 keeps it lit with no period pulses; disable is immediate.
    wr(2, 0, 1);
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1'b0, '0, '0);
      cnt_a += int'(!led[2]);
      cnt_b += int'(cycle_done[2]);
    end
    chk("ch2_always_lit", cnt_a, 0);
    chk("ch2_no_done", cnt_b, 0);
    wr(2, 0, 0);
    idle(1);
    chk("ch2_disable_now", int'(led[2]), 0);
    wr(2, 0, 1);
    idle(5);
    chk("ch2_relit", int'(led[2]), 1);

    // Asynchronous reset mid-run clears outputs before the next clock edge.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_led", int'(led), 0);
    chk("async_reset_done", int'(cycle_done), 0);
    idle(3);
    rst_n = 1'b1;
    cnt_a = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1'b0, '0, '0);
      cnt_a += int'(led != '0) + int'(cycle_done != '0);
    end
    chk("post_reset_idle", cnt_a, 0);

    // Periods were cleared by reset: enabling now lands in a dark OFF loop.
    wr(0, 0, 1);
    cnt_a = 0;
    for (int i = 0; i < 50; i++) begin cyc(1'b0, '0, '0); cnt_a += int'(led[0]); end
    chk("post_reset_on0_dark", cnt_a, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
